rf_read_bypass: RTL and testbench
=================================

Name: rf_read_bypass

Overview:
Register-file block that consumes the writeback stage's selected write data and serves two operand reads to decode.
- Holds NREG x DW architectural registers.
- Tracks in-flight destination writes with per-register pending counters, so decode can stall on RAW hazards.
- Forwards same-cycle writeback data into reads.
- Sits between decode (issue/read side) and the writeback data selector (write side).

Parameters:
NREG, 8, number of architectural registers (power of 2)
DW, 16, register data width
PEND_MAX, 3, max in-flight writes per register (counter saturates here)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd_req  input  1  decode requests operand read this cycle
rd_src1  input  log2(NREG)  source register 1
rd_src2  input  log2(NREG)  source register 2
rd_stall  output  1  combinational: read cannot be accepted this cycle
rd_valid  output  1  registered: rd_data1/rd_data2 valid
rd_data1  output  DW  registered operand 1
rd_data2  output  DW  registered operand 2
iss_en  input  1  instruction issuing with a register destination
iss_dst  input  log2(NREG)  destination register being issued
iss_ready  output  1  combinational: pend_cnt[iss_dst] < PEND_MAX
wb_en  input  1  writeback strobe
wb_reg  input  log2(NREG)  writeback destination
wb_data  input  DW  writeback data (writedata from writeback select)
err_underflow  output  1  sticky: wb_en seen with pend_cnt[wb_reg]==0

Behaviour:
- Reset, asynchronous, rst_n low:
  - all registers, pend_cnt, rd_valid and err_underflow go to 0.
  - rd_data1/rd_data2 go to 0.
  - Reset mid-operation discards all pending state; first post-reset cycle is idle.
- Write:
  - On a clk edge with wb_en=1, reg[wb_reg] <= wb_data.
  - pend_cnt[wb_reg] decrements unless it is 0. In that case it stays at 0 and err_underflow is set.
- Issue:
  - On a clk edge with iss_en=1 and iss_ready=1, pend_cnt[iss_dst] increments.
  - iss_en with iss_ready=0 is ignored. Counter is unchanged; the issuer must hold the request.
- Issue and writeback in the same cycle to the same register: count unchanged, write still performed.
- Hazard, per source s:
  - hz(s) = pend_cnt[s] != 0, except when wb_en && wb_reg==s && pend_cnt[s]==1. That is the final write arriving now, so there is no hazard.
  - rd_stall = rd_req && (hz(rd_src1) || hz(rd_src2)).
- Read latency is 1 cycle.
  - If rd_req && !rd_stall at an edge: rd_valid <= 1 and rd_dataN <= (wb_en && wb_reg==rd_srcN) ? wb_data : reg[rd_srcN].
  - Otherwise rd_valid <= 0 and rd_dataN hold their values.
- rd_src1==rd_src2 is legal; both outputs are identical.
- Issue does not affect reads in the same cycle: the hazard is computed from pre-edge counts.
- Counter width is clog2(PEND_MAX+1) bits. It never wraps, because of the saturation and floor rules above.

Optional Feature:
RF_BYPASS_EN
- Defined: same-cycle writeback forwarding and the pend_cnt==1 hazard exception are active, as described above.
- Undefined: reads always return reg[src] as stored. hz(s) = pend_cnt[s] != 0, so a read waits one extra cycle for the write to land. All other behaviour is identical.

Decomposition:
- Package rf_pkg holds:
  - constants NREG_D=8, DW_D=16, PEND_MAX_D=3;
  - derived AW=clog2(NREG) and PW=clog2(PEND_MAX+1);
  - typedefs reg_idx_t [AW-1:0], word_t [DW-1:0], pend_t [PW-1:0].
- One sub-module rf_pend_cnt (instantiated NREG times):
  - inputs inc, dec;
  - outputs cnt, full (cnt==PEND_MAX), zero;
  - flags underflow on dec at zero.

Test Plan:
- Reset then read: rd_req, src1=3, src2=5 -> next cycle rd_valid=1, rd_data1=0x0000, rd_data2=0x0000, rd_stall=0 throughout.
- Plain write/read: wb_en reg 2 data 0xBEEF (pend 0, err_underflow set) -> err_underflow=1. After reset, iss_en dst 2, then wb 0xBEEF, then read src1=2 -> rd_data1=0xBEEF, err_underflow=0.
- RAW stall and bypass:
  - iss_en dst 4; next cycle rd_req src1=4 -> rd_stall=1 until the cycle wb_en reg 4 data 0x1234 arrives.
  - With RF_BYPASS_EN: stall drops that cycle and rd_data1=0x1234 next cycle.
  - Without it: stall for one further cycle, then rd_data1=0x1234.
- Saturation: three iss_en to dst 1 -> iss_ready=0 for dst 1. A fourth iss_en is ignored. Three wb to reg 1 are needed before a read of 1 is accepted.
- Simultaneous issue+wb to reg 6 with pend_cnt=1 -> pend_cnt stays 1. reg6 updated; a read of 6 still stalls.
- Async reset asserted mid-stall (pend_cnt[4]=2) -> immediately rd_valid=0, and after release a read of 4 has no stall and returns 0x0000.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the register file with read bypass.
// RF_BYPASS_EN enables same-cycle writeback forwarding in rf_read_bypass.
package rf_pkg;

  localparam int unsigned NREG_D     = 8;
  localparam int unsigned DW_D       = 16;
  localparam int unsigned PEND_MAX_D = 3;

  localparam int unsigned AW = $clog2(NREG_D);
  localparam int unsigned PW = $clog2(PEND_MAX_D + 1);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [DW_D-1:0] word_t;
  typedef logic [PW-1:0]   pend_t;

endpackage

// File: rtl/rf_pend_cnt.sv
// Per-register in-flight write counter: saturates at PEND_MAX, floors at zero.
module rf_pend_cnt #(
  parameter int unsigned PEND_MAX = rf_pkg::PEND_MAX_D,
  parameter int unsigned PW       = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] cnt,
  output logic          full,
  output logic          zero,
  output logic          underflow
);

  logic [PW-1:0] cnt_q, cnt_d;

  assign cnt       = cnt_q;
  assign full      = (cnt_q == PW'(PEND_MAX));
  assign zero      = (cnt_q == '0);
  assign underflow = dec && zero;

  always_comb begin
    cnt_d = cnt_q;
    // Issue and writeback together cancel out.
    if (inc && !dec && !full) begin
      cnt_d = cnt_q + PW'(1);
    end else if (dec && !inc && !zero) begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_read_bypass.sv
// Register file with pending-write hazard tracking and two 1-cycle operand reads.
// `define RF_BYPASS_EN to forward same-cycle writeback data into reads.
module rf_read_bypass
  import rf_pkg::*;
#(
  parameter int unsigned NREG     = NREG_D,
  parameter int unsigned DW       = DW_D,
  parameter int unsigned PEND_MAX = PEND_MAX_D,
  localparam int unsigned Aw      = $clog2(NREG),
  localparam int unsigned Pw      = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [Aw-1:0] rd_src1,
  input  logic [Aw-1:0] rd_src2,
  output logic          rd_stall,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  input  logic          iss_en,
  input  logic [Aw-1:0] iss_dst,
  output logic          iss_ready,
  input  logic          wb_en,
  input  logic [Aw-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          err_underflow
);

  logic [Pw-1:0] cnt [NREG];
  logic [NREG-1:0] full, zero, uflow;
  logic [DW-1:0]   regs_q [NREG];
  logic            hz1, hz2, rd_fire;
  logic [DW-1:0]   fwd1, fwd2;

  for (genvar i = 0; i < NREG; i++) begin : g_pend
    rf_pend_cnt #(
      .PEND_MAX (PEND_MAX),
      .PW       (Pw)
    ) u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (iss_en && (iss_dst == Aw'(i)) && !full[i]),
      .dec       (wb_en && (wb_reg == Aw'(i))),
      .cnt       (cnt[i]),
      .full      (full[i]),
      .zero      (zero[i]),
      .underflow (uflow[i])
    );
  end

  assign iss_ready = !full[iss_dst];

`ifdef RF_BYPASS_EN
  // The last outstanding write landing this cycle is forwarded, so it is not a hazard.
  assign hz1  = !zero[rd_src1] && !(wb_en && wb_reg == rd_src1 && cnt[rd_src1] == Pw'(1));
  assign hz2  = !zero[rd_src2] && !(wb_en && wb_reg == rd_src2 && cnt[rd_src2] == Pw'(1));
  assign fwd1 = (wb_en && wb_reg == rd_src1) ? wb_data : regs_q[rd_src1];
  assign fwd2 = (wb_en && wb_reg == rd_src2) ? wb_data : regs_q[rd_src2];
`else
  assign hz1  = !zero[rd_src1];
  assign hz2  = !zero[rd_src2];
  assign fwd1 = regs_q[rd_src1];
  assign fwd2 = regs_q[rd_src2];
`endif

  assign rd_stall = rd_req && (hz1 || hz2);
  assign rd_fire  = rd_req && !rd_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid      <= 1'b0;
      rd_data1      <= '0;
      rd_data2      <= '0;
      err_underflow <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_data1 <= fwd1;
        rd_data2 <= fwd2;
      end
      if (|uflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_read_bypass.sv
// Directed bench for rf_read_bypass; expectations follow RF_BYPASS_EN if defined.
module tb_rf_read_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [2:0]  rd_src1, rd_src2;
  logic        rd_stall, rd_valid;
  logic [15:0] rd_data1, rd_data2;
  logic        iss_en;
  logic [2:0]  iss_dst;
  logic        iss_ready;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        err_underflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_read_bypass dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_req        (rd_req),
    .rd_src1       (rd_src1),
    .rd_src2       (rd_src2),
    .rd_stall      (rd_stall),
    .rd_valid      (rd_valid),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2),
    .iss_en        (iss_en),
    .iss_dst       (iss_dst),
    .iss_ready     (iss_ready),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    rd_req = 0; iss_en = 0; wb_en = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    rd_src1 = 0; rd_src2 = 0; iss_dst = 0; wb_reg = 0; wb_data = 0;
    #12;
    chk("rst_valid", rd_valid, 0);
    chk("rst_data1", rd_data1, 0);
    chk("rst_data2", rd_data2, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_stall", rd_stall, 0);
    rst_n = 1;
    tick();

    // Read straight after reset
    rd_req = 1; rd_src1 = 3; rd_src2 = 5; settle();
    chk("r0_stall", rd_stall, 0);
    tick();
    chk("r0_valid", rd_valid, 1);
    chk("r0_d1", rd_data1, 16'h0000);
    chk("r0_d2", rd_data2, 16'h0000);
    idle(); tick();
    chk("r0_valid_drop", rd_valid, 0);

    // Writeback with nothing pending sets the sticky error
    wb_en = 1; wb_reg = 2; wb_data = 16'hBEEF; tick();
    idle(); tick();
    chk("uflow_set", err_underflow, 1);
    #2 rst_n = 0; #1;
    chk("uflow_clr", err_underflow, 0);
    rst_n = 1; tick();

    // Issue, write, read
    iss_en = 1; iss_dst = 2; settle();
    chk("iss_ready2", iss_ready, 1);
    tick(); idle();
    wb_en = 1; wb_reg = 2; wb_data = 16'hBEEF; tick(); idle();
    rd_req = 1; rd_src1 = 2; rd_src2 = 2; settle();
    chk("w_stall", rd_stall, 0);
    tick();
    chk("w_d1", rd_data1, 16'hBEEF);
    chk("w_d2", rd_data2, 16'hBEEF);
    chk("w_err", err_underflow, 0);
    idle(); tick();

    // RAW stall on reg 4
    iss_en = 1; iss_dst = 4; tick(); idle();
    rd_req = 1; rd_src1 = 4; rd_src2 = 0; settle();
    chk("raw_stall0", rd_stall, 1);
    tick();
    chk("raw_stall1", rd_stall, 1);
    chk("raw_novalid", rd_valid, 0);
    wb_en = 1; wb_reg = 4; wb_data = 16'h1234; settle();
`ifdef RF_BYPASS_EN
    chk("raw_wb_stall", rd_stall, 0);
    tick();
`else
    chk("raw_wb_stall", rd_stall, 1);
    tick();
    wb_en = 0; settle();
    chk("raw_post_stall", rd_stall, 0);
    chk("raw_post_novalid", rd_valid, 0);
    tick();
`endif
    chk("raw_valid", rd_valid, 1);
    chk("raw_d1", rd_data1, 16'h1234);
    idle(); tick();

    // Saturation on reg 1
    iss_en = 1; iss_dst = 1;
    tick(); tick(); tick();
    chk("sat_ready", iss_ready, 0);
    tick(); idle();
    rd_req = 1; rd_src1 = 1; rd_src2 = 1;
    wb_en = 1; wb_reg = 1; wb_data = 16'h0111; settle();
    chk("sat_stall3", rd_stall, 1);
    tick();
    wb_data = 16'h0222; settle();
    chk("sat_stall2", rd_stall, 1);
    tick();
    wb_data = 16'h0333; settle();
`ifdef RF_BYPASS_EN
    chk("sat_stall1", rd_stall, 0);
    tick();
`else
    chk("sat_stall1", rd_stall, 1);
    tick();
    wb_en = 0; settle();
    chk("sat_stall0", rd_stall, 0);
    tick();
`endif
    chk("sat_valid", rd_valid, 1);
    chk("sat_d1", rd_data1, 16'h0333);
    idle(); settle();
    chk("sat_ready_back", iss_ready, 1);
    chk("sat_err", err_underflow, 0);
    tick();

    // Simultaneous issue and writeback on reg 6
    iss_en = 1; iss_dst = 6; tick();
    wb_en = 1; wb_reg = 6; wb_data = 16'h6666; tick(); idle();
    rd_req = 1; rd_src1 = 6; rd_src2 = 2; settle();
    chk("sim_stall", rd_stall, 1);
    chk("sim_err", err_underflow, 0);
    rd_req = 0;
    wb_en = 1; wb_reg = 6; wb_data = 16'h7777; tick(); idle();
    rd_req = 1; settle();
    chk("sim_drain_stall", rd_stall, 0);
    tick();
    chk("sim_d1", rd_data1, 16'h7777);
    chk("sim_d2", rd_data2, 16'hBEEF);
    chk("sim_err2", err_underflow, 0);
    idle(); tick();

    // Async reset while reg 4 has two writes pending
    iss_en = 1; iss_dst = 4; tick(); tick(); idle();
    rd_req = 1; rd_src1 = 2; rd_src2 = 2; tick();
    chk("ar_pre_valid", rd_valid, 1);
    rd_src1 = 4; rd_src2 = 4; settle();
    chk("ar_pre_stall", rd_stall, 1);
    #2 rst_n = 0; #1;
    chk("ar_valid", rd_valid, 0);
    chk("ar_d1", rd_data1, 0);
    #1 rst_n = 1; settle();
    chk("ar_stall", rd_stall, 0);
    tick();
    chk("ar_rd_valid", rd_valid, 1);
    chk("ar_rd_d1", rd_data1, 16'h0000);
    chk("ar_rd_d2", rd_data2, 16'h0000);
    idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
